seq_bit_serializer: RTL and testbench

//   Upstream feeder for the 1011 sequence detector. Accepts parallel words on a

---
 rtl/seq_bit_serializer_if.sv | 27 ++
 rtl/seq_bit_serializer.sv | 122 ++++++++++++
 tb/tb_seq_bit_serializer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bundle for the serializer: parallel word handshake plus
// the serial bit stream toward the sequence detector.
interface seq_bit_serializer_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              bit_en;
    logic              bit_out;
    logic              bit_valid;
    logic              word_start;
    logic              busy;

    // Word handshake: a word transfers on the rising edge where s_valid && s_ready.
    // s_valid may drop at any time without a transfer; s_ready is combinational.
    // A serial bit is consumed on the rising edge where bit_valid && bit_en.
    modport master (
        output s_data, s_valid, bit_en,
        input  s_ready, bit_out, bit_valid, word_start, busy
    );

    modport slave (
        input  s_data, s_valid, bit_en,
        output s_ready, bit_out, bit_valid, word_start, busy
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 1011 detector: gapless back-to-back words,
// bit rate throttled by bit_en, configurable bit order and idle level.
module seq_bit_serializer #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bit_serializer_if.slave  bus
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sreg, sreg_n;
    logic              bit_out, bit_out_n;
    logic              bit_valid, bit_valid_n;
    logic              word_start, word_start_n;

    logic              last;
    logic              ready;
    logic              accept;
    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] load_sreg;
    logic [DATA_W-1:0] shift_sreg;

    // sreg only holds the bits not yet presented; bit_out carries the current one.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit  = bus.s_data[DATA_W-1];
            load_sreg  = bus.s_data << 1;
            next_bit   = sreg[DATA_W-1];
            shift_sreg = sreg << 1;
        end else begin
            first_bit  = bus.s_data[0];
            load_sreg  = bus.s_data >> 1;
            next_bit   = sreg[0];
            shift_sreg = sreg >> 1;
        end
    end

    assign last   = (cnt == LAST);
    assign ready  = (state == IDLE) || ((state == SHIFT) && last && bus.bit_en);
    assign accept = ready && bus.s_valid;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        sreg_n       = sreg;
        bit_out_n    = bit_out;
        bit_valid_n  = bit_valid;
        word_start_n = word_start;

        if (accept) begin
            state_n      = SHIFT;
            cnt_n        = '0;
            sreg_n       = load_sreg;
            bit_out_n    = first_bit;
            bit_valid_n  = 1'b1;
            word_start_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bit_out_n    = IDLE_BIT;
                    bit_valid_n  = 1'b0;
                    word_start_n = 1'b0;
                end
                SHIFT: begin
                    if (bus.bit_en) begin
                        if (!last) begin
                            cnt_n        = cnt + 1'b1;
                            sreg_n       = shift_sreg;
                            bit_out_n    = next_bit;
                            word_start_n = 1'b0;
                        end else begin
                            state_n      = IDLE;
                            cnt_n        = '0;
                            bit_out_n    = IDLE_BIT;
                            bit_valid_n  = 1'b0;
                            word_start_n = 1'b0;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            bit_out    <= IDLE_BIT;
            bit_valid  <= 1'b0;
            word_start <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sreg       <= sreg_n;
            bit_out    <= bit_out_n;
            bit_valid  <= bit_valid_n;
            word_start <= word_start_n;
        end
    end

    assign bus.s_ready    = ready;
    assign bus.bit_out    = bit_out;
    assign bus.bit_valid  = bit_valid;
    assign bus.word_start = word_start;
    assign bus.busy       = (state == SHIFT);
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share one
// stimulus stream; a word-level model predicts handshakes and serial bits.
module tb_seq_bit_serializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.DATA_W(W)) m_if ();
    seq_bit_serializer_if #(.DATA_W(W)) l_if ();

    assign l_if.s_data  = m_if.s_data;
    assign l_if.s_valid = m_if.s_valid;
    assign l_if.bit_en  = m_if.bit_en;

    seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    seq_bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_if)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    int left = 0;
    int pos = 0;
    int model_acc = 0;
    int dut_acc = 0;
    int en_mode = 0;
    int en_phase = 0;
    logic [3:0] det_win = 4'b0;
    int det_hits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // bit_en generator: 0 = always on, 1 = random, 2 = repeating 1,0,0,1
    always @(posedge clk) begin
        #1;
        case (en_mode)
            0: m_if.bit_en = 1'b1;
            1: m_if.bit_en = ($urandom_range(0, 3) != 0);
            default: begin
                m_if.bit_en = ((en_phase % 4) == 0) || ((en_phase % 4) == 3);
                en_phase++;
            end
        endcase
    end

    // Reference model: words in flight counted in remaining bit slots
    always @(posedge clk) begin
        if (rst) begin
            left = 0;
            exp_q.delete();
        end else begin
            logic rdy;
            rdy = (left == 0) || ((left == 1) && m_if.bit_en);
            if (left > 0 && m_if.bit_en) left--;
            if (m_if.s_valid && rdy) begin
                left = W;
                exp_q.push_back(m_if.s_data);
                model_acc++;
            end
        end
    end

    // Monitor: compare the DUT outputs against the model between edges
    always @(negedge clk) begin
        if (rst) begin
            pos = 0;
        end else begin
            logic exp_busy;
            logic exp_ready;
            logic [W-1:0] cur;
            exp_busy  = (left > 0);
            exp_ready = (left == 0) || ((left == 1) && m_if.bit_en);
            check("msb_bit_valid", 32'(m_if.bit_valid), 32'(exp_busy));
            check("msb_busy", 32'(m_if.busy), 32'(exp_busy));
            check("msb_s_ready", 32'(m_if.s_ready), 32'(exp_ready));
            check("lsb_bit_valid", 32'(l_if.bit_valid), 32'(exp_busy));
            check("lsb_s_ready", 32'(l_if.s_ready), 32'(exp_ready));
            if (m_if.s_valid && m_if.s_ready) dut_acc++;
            if (exp_busy) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    cur = exp_q[0];
                    check("msb_bit_out", 32'(m_if.bit_out), 32'(cur[W-1-pos]));
                    check("lsb_bit_out", 32'(l_if.bit_out), 32'(cur[pos]));
                    check("msb_word_start", 32'(m_if.word_start), 32'(pos == 0));
                    check("lsb_word_start", 32'(l_if.word_start), 32'(pos == 0));
                    if (m_if.bit_en) begin
                        det_win = {det_win[2:0], m_if.bit_out};
                        if (det_win == 4'b1011) det_hits++;
                        pos++;
                        if (pos == W) begin
                            pos = 0;
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end else begin
                check("msb_idle_bit", 32'(m_if.bit_out), 32'd0);
                check("lsb_idle_bit", 32'(l_if.bit_out), 32'd0);
                check("msb_idle_word_start", 32'(m_if.word_start), 32'd0);
            end
        end
    end

    // Hold s_valid with word d until the accept edge; leaves s_valid high
    task automatic send(input logic [W-1:0] d);
        int t;
        t = 0;
        m_if.s_valid = 1'b1;
        m_if.s_data  = d;
        @(negedge clk);
        while (!m_if.s_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no s_ready expected s_ready within 200 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
        m_if.s_data = W'($urandom);
    endtask

    task automatic idle(input int n);
        m_if.s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int hits0;
        rst = 1'b1;
        m_if.s_valid = 1'b0;
        m_if.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // single word, continuous slots
        send(8'hB0);
        idle(12);

        // back-to-back words; one 1011 match straddles the boundary
        hits0 = det_hits;
        send(8'h05);
        send(8'h80);
        idle(20);
        check("detector_hits", 32'(det_hits - hits0), 32'd1);

        // stalled slots
        en_mode = 2;
        send(8'hA5);
        idle(40);
        en_mode = 0;
        idle(2);

        // reset mid-word at cnt=3, then a clean word
        send(8'hFF);
        m_if.s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h0F);
        idle(12);

        // word for the LSB-first instance
        send(8'h0D);
        idle(12);

        // s_valid toggling with changing s_data, random slot enables
        en_mode = 1;
        for (int i = 0; i < 400; i++) begin
            m_if.s_valid = 1'($urandom_range(0, 1));
            m_if.s_data  = W'($urandom);
            @(posedge clk);
            #1;
        end
        m_if.s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 6));
        end
        en_mode = 0;
        idle(30);

        check("accept_count", 32'(dut_acc), 32'(model_acc));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
